// File: rtl/music_box_state_controller.sv
// Mode sequencer for the music box: turns button presses into currentState and returns to
// DoNothing on completion, cancel or (with MUSICBOX_WATCHDOG_EN defined) watchdog expiry.
module music_box_state_controller #(
  parameter int unsigned WATCHDOG_CYCLES = 32'd500_000_000
) (
  input  logic        clock_50Mhz,
  input  logic        reset,
  input  logic [3:0]  button_n,
  input  logic        cancel_n,
  input  logic [3:0]  stateComplete,
  output logic [4:0]  currentState,
  output logic        stateEntered,
  output logic        watchdogFired,
  output logic [31:0] debugString
);

  typedef enum logic [4:0] {
    StDoNothing     = 5'd0,
    StMakeRecording = 5'd1,
    StPlayRecording = 5'd2,
    StPlaySong1     = 5'd3,
    StPlaySong2     = 5'd4
  } state_e;

  state_e      r_state;
  state_e      w_state_d;
  logic [4:0]  r_prev;
  logic [15:0] r_count;
  logic        r_entered;
  logic        r_wd_fired;

  // Packed as {complete[3:0], cancel, button[3:0]}, all active-high.
  logic [8:0]  w_in;
  logic [8:0]  r_sync1;
  logic [8:0]  r_sync2;
  logic [8:0]  r_hist;
  logic [8:0]  w_event;
  logic [3:0]  w_btn_ev;
  logic        w_cancel_ev;
  logic [3:0]  w_cmp_ev;

  logic        w_cmp_hit;
  logic        w_wd_expire;
  logic        w_wd_exit;
  logic        w_transition;
  logic        w_btn_accept;

  assign w_in        = {stateComplete, ~cancel_n, ~button_n};
  assign w_event     = r_sync2 & ~r_hist;
  assign w_btn_ev    = w_event[3:0];
  assign w_cancel_ev = w_event[4];
  assign w_cmp_ev    = w_event[8:5];

  always_comb begin
    w_state_d = r_state;
    w_cmp_hit = 1'b0;
    w_wd_exit = 1'b0;
    case (r_state)
      StDoNothing: begin
        if (w_btn_ev[0])      w_state_d = StMakeRecording;
        else if (w_btn_ev[1]) w_state_d = StPlayRecording;
        else if (w_btn_ev[2]) w_state_d = StPlaySong1;
        else if (w_btn_ev[3]) w_state_d = StPlaySong2;
      end
      StMakeRecording: w_cmp_hit = w_cmp_ev[0];
      StPlayRecording: w_cmp_hit = w_cmp_ev[1];
      StPlaySong1:     w_cmp_hit = w_cmp_ev[2];
      StPlaySong2:     w_cmp_hit = w_cmp_ev[3];
      default:         w_state_d = StDoNothing;
    endcase
    if (r_state != StDoNothing) begin
      // Completion or cancel take precedence so the watchdog flag blames only a pure timeout.
      if (w_cmp_hit || w_cancel_ev) begin
        w_state_d = StDoNothing;
      end else if (w_wd_expire) begin
        w_state_d = StDoNothing;
        w_wd_exit = 1'b1;
      end
    end
  end

  assign w_transition = (w_state_d != r_state);
  assign w_btn_accept = w_transition && (r_state == StDoNothing);

  always_ff @(posedge clock_50Mhz) begin
    if (reset) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_hist     <= '0;
      r_state    <= StDoNothing;
      r_prev     <= '0;
      r_count    <= '0;
      r_entered  <= 1'b0;
      r_wd_fired <= 1'b0;
    end else begin
      r_sync1   <= w_in;
      r_sync2   <= r_sync1;
      r_hist    <= r_sync2;
      r_state   <= w_state_d;
      r_entered <= w_transition;
      if (w_transition) begin
        r_prev  <= r_state;
        r_count <= r_count + 16'd1;
      end
      if (w_wd_exit)         r_wd_fired <= 1'b1;
      else if (w_btn_accept) r_wd_fired <= 1'b0;
    end
  end

`ifdef MUSICBOX_WATCHDOG_EN
  logic [31:0] r_wd_cnt;

  assign w_wd_expire = (r_state != StDoNothing) && (r_wd_cnt == 32'(WATCHDOG_CYCLES - 1));

  always_ff @(posedge clock_50Mhz) begin
    if (reset) begin
      r_wd_cnt <= '0;
    end else if (w_transition || (r_state == StDoNothing)) begin
      r_wd_cnt <= '0;
    end else begin
      r_wd_cnt <= r_wd_cnt + 32'd1;
    end
  end
`else
  logic w_unused_wd;

  assign w_wd_expire = 1'b0;
  assign w_unused_wd = ^WATCHDOG_CYCLES;
`endif

  assign currentState  = r_state;
  assign stateEntered  = r_entered;
  assign watchdogFired = r_wd_fired;
  assign debugString   = {3'b000, r_prev, 3'b000, r_state, r_count};

endmodule

// File: doc/music_box_state_controller.md
# music_box_state_controller

Top-level mode sequencer for the music box. Converts user button presses into a 5-bit `currentState` that is broadcast to every state module (MakeRecording, PlayRecording, PlaySong1, PlaySong2). It returns to DoNothing when the active module raises its `stateComplete` flag, when the user presses cancel, or when the optional watchdog expires. It runs on the 50 MHz system clock and consumes completion flags produced in the 1 kHz domain.

## Interface
Parameters:
- `WATCHDOG_CYCLES`, default 32'd500_000_000: maximum number of `clock_50Mhz` cycles spent in any non-DoNothing state (10 s).

Ports:
- `clock_50Mhz`  in  1  sole clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `button_n`  in  4  raw active-low buttons. Bit i requests state i+1: bit 0 = MakeRecording, bit 1 = PlayRecording, bit 2 = PlaySong1, bit 3 = PlaySong2.
- `cancel_n`  in  1  raw active-low cancel button.
- `stateComplete`  in  4  bit i is the completion flag from the module owning state i+1. It is asynchronous to this clock.
- `currentState`  out  5  0 = DoNothing, 1 = MakeRecording, 2 = PlayRecording, 3 = PlaySong1, 4 = PlaySong2. Values 5–31 are never driven.
- `stateEntered`  out  1  one-cycle pulse on the cycle `currentState` takes a new value.
- `watchdogFired`  out  1  sticky flag: the last return to DoNothing was caused by the watchdog.
- `debugString`  out  32  {3'b0, previousState[4:0], 3'b0, currentState[4:0], transitionCount[15:0]}.

## Operation
- **Synchronisation:** the inputs `button_n`, `cancel_n` and `stateComplete` are inverted where active-low. Each then passes through a 2-flop synchroniser and a third history flop. An event is `sync & ~history`, which detects a rising edge of the asserted level.
- **DoNothing (0):**
  - A button event moves to state i+1.
  - On simultaneous button events, the lowest bit index wins; the others are dropped, not queued.
  - Cancel and completion events are ignored.
- **Active states (1–4):**
  - A completion event on bit (currentState−1) moves to DoNothing.
  - A cancel event moves to DoNothing.
  - A watchdog expiry moves to DoNothing.
  - Button events are ignored; there is no direct state-to-state jump.
  - Completion events on other bits are ignored.
- **Stale completion:** a completion flag that is already high on entry does not cause an exit, because the design is edge based. The 1 kHz modules may hold `stateComplete` high for up to 1 ms after `currentState` leaves their state; this must not retrigger anything.
- **Simultaneous exit causes:** when completion, cancel and watchdog fall on the same cycle, the state goes to DoNothing once. `watchdogFired` is set only if the watchdog was among the causes and neither completion nor cancel was.
- **Every transition:**
  - `previousState` ← old `currentState`.
  - `transitionCount` increments by 1 and wraps from 16'hFFFF to 0.
  - `stateEntered` = 1 for that cycle.
- **`watchdogFired`:** set on a watchdog exit; cleared on the next accepted button event.
- **Reset (any time, including mid-state):**
  - `currentState`, `previousState`, `transitionCount` = 0.
  - `stateEntered`, `watchdogFired` = 0.
  - Synchroniser and history flops = 0.
  - Watchdog counter = 0.

## Timing
- **Input latency:** an input level first sampled asserted at edge k gives `sync` = 1 after edge k+1. `currentState` and `stateEntered` update at edge k+2, i.e. three cycles of latency.
- **Back-to-back events:** one transition per cycle maximum. An exit and a new button press cannot occur in the same cycle, because buttons are evaluated only while in DoNothing.
- **Watchdog counter:**
  - 32 bits; cleared on every transition; counts only in states 1–4.
  - When it equals WATCHDOG_CYCLES−1 and no other exit is taken, the next edge transitions to DoNothing.
  - Total dwell is exactly WATCHDOG_CYCLES cycles from the `stateEntered` edge.
- **Output timing:** outputs are registered, with no combinational input-to-output path.

## Configuration
- **`MUSICBOX_WATCHDOG_EN` defined:** the watchdog counter and watchdog exit are compiled in as described above.
- **`MUSICBOX_WATCHDOG_EN` undefined:**
  - No watchdog counter is instantiated.
  - `watchdogFired` is tied to 0.
  - Active states exit only on completion or cancel.
  - `WATCHDOG_CYCLES` is ignored.

## Test plan
All scenarios use WATCHDOG_CYCLES = 100 and start from reset.

1. **Reset:** hold `reset` = 1 for 5 cycles with `button_n` = 4'b0000 → `currentState` = 0, `debugString` = 0, `stateEntered` = 0 throughout.
2. **Press and complete:**
   - Drive `button_n[0]` low at edge k → `currentState` = 1 and `stateEntered` = 1 at edge k+2; `transitionCount` = 1.
   - Then raise `stateComplete[0]` → `currentState` = 0 three cycles later; `previousState` = 1; `transitionCount` = 2.
3. **Priority and stale completion:**
   - Press `button_n[2]` and `button_n[1]` on the same cycle → `currentState` = 2.
   - Drive `stateComplete[0]` and `stateComplete[2]` high → state stays 2.
   - Raise `stateComplete[1]` while it was already held high on entry → state stays 2.
   - Drop `stateComplete[1]` and raise it again → `currentState` = 0.
4. **Cancel and ignored buttons:**
   - In state 4, press any button → no change.
   - Press `cancel_n` → `currentState` = 0 and `watchdogFired` = 0.
   - Press `cancel_n` again while in DoNothing → no change.
5. **Watchdog (macro defined):**
   - Enter state 3 and hold all inputs idle → after exactly 100 cycles from `stateEntered`, `currentState` = 0 and `watchdogFired` = 1.
   - Next button press → `watchdogFired` = 0.
   - With the macro undefined, the same stimulus keeps state 3 for 10 000 cycles.
6. **Reset mid-state and counter wrap:**
   - Assert `reset` for 1 cycle in state 2 → all outputs 0 at the next edge.
   - Force 65 536 transitions → `transitionCount` wraps to 0.
